// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
//
// Sequential radix-2 shift-add multiplier that sits in the EX stage, right
// after the ALU control decoder. It starts only when the decoded ALU code is
// MUL_CODE. It then takes WIDTH iterations to build the 2*WIDTH-bit product,
// and it stalls the pipeline while it works. Every other ALU code is left to
// the combinational ALU.
//
// Signed multiplies run on operand magnitudes. The sign is applied once, at
// the end. The adder is WIDTH+1 bits wide so that |0x80..0| * |0x80..0| does
// not drop a carry.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   EX-stage instruction valid, qualified by alu_ctrl
//   alu_ctrl   in   5-bit ALU control code
//   sign       in   1 = signed multiply, 0 = unsigned
//   op_a       in   multiplicand
//   op_b       in   multiplier
//   flush      in   pipeline flush, aborts any operation in progress
//   stall      out  combinational pipeline hold
//   busy       out  state != IDLE
//   done       out  one-cycle pulse with a valid result
//   result_lo  out  low half of the product
//   result_hi  out  high half of the product
//
// FSM
//   state  | meaning
//   IDLE   | waiting for an accepted MUL
//   CALC   | one shift-add iteration per cycle, WIDTH cycles in total
//   DONE   | apply the sign, register the product and pulse done on exit
// ---------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int          WIDTH    = 32,
  parameter logic [4:0]  MUL_CODE = 5'b11010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       alu_ctrl,
  input  logic             sign,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               done_q, done_d;

  logic               accept;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] product;

  assign accept = start & (alu_ctrl == MUL_CODE) & (state_q == S_IDLE) & ~flush;

  // Negating the most negative value gives back the same bit pattern.
  // Read as unsigned, that pattern is the correct magnitude.
  assign abs_a = (sign & op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
  assign abs_b = (sign & op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;

  // One iteration: add into the upper half, then shift {carry, acc} right.
  assign addend   = mplier_q[0] ? mcand_q : '0;
  assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_step = {sum, acc_q[WIDTH-1:1]};

  assign product  = neg_q ? (~acc_q + 1'b1) : acc_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_CALC;
      end
      S_CALC: begin
        if (flush)                  state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    stall = accept | (state_q == S_CALC);
    busy  = (state_q != S_IDLE);
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mcand_d  = abs_a;
          mplier_d = abs_b;
          neg_d    = sign & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_CALC: begin
        if (!flush) begin
          acc_d    = acc_step;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // A flush here drops the result and keeps the previous one visible.
        if (!flush) begin
          res_lo_d = product[WIDTH-1:0];
          res_hi_d = product[2*WIDTH-1:WIDTH];
          done_d   = 1'b1;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      done_q   <= done_d;
    end
  end

  assign done      = done_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

  localparam logic [4:0] MUL = 5'b11010;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  alu_ctrl;
  logic        sign;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall, busy, done;
  logic [31:0] result_lo, result_hi;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] last_hi, last_lo;

  alu_mul_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .alu_ctrl  (alu_ctrl),
    .sign      (sign),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge. Returns at the negedge where done is seen, so a
  // following call drives start during the done-pulse cycle.
  task automatic run_mul(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic [31:0] ehi, input logic [31:0] elo,
                         input string nm);
    int lat;
    int stall_cnt;
    start = 1'b1; alu_ctrl = MUL; sign = sg; op_a = a; op_b = b;
    #1 chk({nm, " accept stall"}, 64'(stall), 64'(1));
    @(posedge clk);
    @(negedge clk);
    chk({nm, " done low after accept"}, 64'(done), 64'(0));
    lat = -1;
    stall_cnt = 0;
    for (int n = 0; n < 60; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (stall) stall_cnt++;
      if (n >= hold) start = 1'b0;
      op_a = 32'hA5A5_5A5A ^ 32'(n);
      op_b = 32'h3C3C_C3C3 ^ 32'(n);
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'(33));
    chk({nm, " stall cycles"}, 64'(stall_cnt), 64'(32));
    chk({nm, " busy at done"}, 64'(busy), 64'(0));
    chk({nm, " product"}, {result_hi, result_lo}, {ehi, elo});
    last_hi = ehi;
    last_lo = elo;
  endtask

  initial begin
    int seen;
    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[7] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
    vecs[8] = '{1'b1, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

    reset = 1'b1; start = 1'b0; alu_ctrl = 5'd0; sign = 1'b0;
    op_a = 32'd0; op_b = 32'd0; flush = 1'b0;
    last_hi = 32'd0; last_lo = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset stall", 64'(stall), 64'(0));
    chk("reset results", {result_hi, result_lo}, 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Table vectors, back to back: each start lands in the previous done cycle.
    for (int i = 0; i < 10; i++)
      run_mul(vecs[i].sgn, vecs[i].a, vecs[i].b, 0, vecs[i].hi, vecs[i].lo,
              $sformatf("vec%0d", i));
    @(negedge clk);

    // Non-MUL code is ignored.
    start = 1'b1; alu_ctrl = 5'b00010; sign = 1'b0; op_a = 32'd7; op_b = 32'd9;
    #1 chk("add stall", 64'(stall), 64'(0));
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (busy || done || stall) seen++;
    end
    start = 1'b0;
    chk("add no activity", 64'(seen), 64'(0));
    chk("add results hold", {result_hi, result_lo}, {last_hi, last_lo});

    // Flush at CALC cycle 10.
    start = 1'b1; alu_ctrl = MUL; sign = 1'b0; op_a = 32'd3; op_b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush busy before", 64'(busy), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy after", 64'(busy), 64'(0));
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("flush no done", 64'(seen), 64'(0));
    chk("flush results hold", {result_hi, result_lo}, {last_hi, last_lo});
    run_mul(1'b0, 32'd3, 32'd4, 0, 32'd0, 32'd12, "after flush");
    @(negedge clk);

    // Flush and start together in IDLE.
    start = 1'b1; alu_ctrl = MUL; op_a = 32'd5; op_b = 32'd5; flush = 1'b1;
    #1 chk("flush+start stall", 64'(stall), 64'(0));
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush+start busy", 64'(busy), 64'(0));

    // Start held high through part of CALC; operands scrambled meanwhile.
    run_mul(1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 20, 32'hFFFF_FFFF, 32'hFFFF_FFD6, "held start");
    @(negedge clk);

    // Reset at CALC cycle 5.
    start = 1'b1; alu_ctrl = MUL; sign = 1'b0; op_a = 32'd100; op_b = 32'd100;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst done", 64'(done), 64'(0));
    chk("midrst stall", 64'(stall), 64'(0));
    chk("midrst results", {result_hi, result_lo}, 64'(0));
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("midrst no done", 64'(seen), 64'(0));
    run_mul(1'b0, 32'd6, 32'd7, 0, 32'd0, 32'd42, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
